// File: rtl/mem_access.sv
// Memory-access pipeline stage: latches execute results, issues data-memory requests for LD/ST/LDR,
// and stalls upstream until acknowledged. Optional ack timeout enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_mem_next,
    input  logic [31:0] ir_mem_next,
    input  logic [31:0] y_mem_next,
    input  logic [31:0] st_mem_next,
    input  logic [1:0]  ir_src_mem,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_wb_next,
    output logic [31:0] ir_wb_next,
    output logic [31:0] y_wb_next,
    output logic [31:0] ld_wb_next,
    output logic        bus_err
);

    localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
    localparam logic [1:0]  IR_SRC_NOP      = 2'd1;
    localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd2;
    localparam logic [31:0] INST_NOP        = 32'h0000_0000;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'hB000_0000;
    localparam logic [5:0]  OP_LD           = 6'b011000;
    localparam logic [5:0]  OP_ST           = 6'b011001;
    localparam logic [5:0]  OP_LDR          = 6'b011111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT
`ifdef MEM_ACCESS_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_mem_q, pc_mem_d;
    logic [31:0] ir_mem_q, ir_mem_d;
    logic [31:0] y_mem_q, y_mem_d;
    logic [31:0] st_mem_q, st_mem_d;
    logic        is_mem_op;
    logic        live_op;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // A killed op (ir_src_mem != DATA) in its first cycle never reaches the bus.
    always_comb begin
        is_mem_op = (ir_mem_q[31:26] == OP_LD) || (ir_mem_q[31:26] == OP_ST) ||
                    (ir_mem_q[31:26] == OP_LDR);
        live_op   = is_mem_op && (ir_src_mem == IR_SRC_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_mem_q <= '0;
            ir_mem_q <= INST_NOP;
            y_mem_q  <= '0;
            st_mem_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_mem_q <= pc_mem_d;
            ir_mem_q <= ir_mem_d;
            y_mem_q  <= y_mem_d;
            st_mem_q <= st_mem_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        pc_mem_d = mem_stall ? pc_mem_q : pc_mem_next;
        ir_mem_d = mem_stall ? ir_mem_q : ir_mem_next;
        y_mem_d  = mem_stall ? y_mem_q  : y_mem_next;
        st_mem_d = mem_stall ? st_mem_q : st_mem_next;
    end

    always_comb begin
        state_d = state_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (live_op && !dmem_ack) begin
                    state_d = S_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack)
                    state_d = S_IDLE;
                else if (cnt_d == CNT_W'(TIMEOUT_CYCLES))
                    state_d = S_ABORT;
`else
                if (dmem_ack)
                    state_d = S_IDLE;
`endif
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
            S_ABORT: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = (state_q == S_WAIT) || ((state_q == S_IDLE) && live_op);
        dmem_we    = ir_mem_q[31:26] == OP_ST;
        dmem_addr  = y_mem_q;
        dmem_wdata = st_mem_q;
        mem_stall  = dmem_req && !dmem_ack;
        ld_wb_next = (dmem_req && dmem_ack) ? dmem_rdata : '0;
        pc_wb_next = pc_mem_q;
        y_wb_next  = y_mem_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        bus_err    = state_q == S_ABORT;
`else
        bus_err    = 1'b0;
`endif
        if (bus_err)
            ir_wb_next = INST_BNE_EXCEPT;
        else if (mem_stall)
            ir_wb_next = INST_NOP;
        else begin
            case (ir_src_mem)
                IR_SRC_DATA:   ir_wb_next = ir_mem_q;
                IR_SRC_EXCEPT: ir_wb_next = INST_BNE_EXCEPT;
                IR_SRC_NOP:    ir_wb_next = INST_NOP;
                default:       ir_wb_next = INST_NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; timeout scenario runs when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access;

    localparam logic [1:0]  SRC_DATA   = 2'd0;
    localparam logic [1:0]  SRC_NOP    = 2'd1;
    localparam logic [1:0]  SRC_EXCEPT = 2'd2;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] BNE_EXC    = 32'hB000_0000;
    localparam logic [31:0] I_LD       = {6'b011000, 26'h0000_021};
    localparam logic [31:0] I_ST       = {6'b011001, 26'h0000_042};
    localparam logic [31:0] I_ADD      = {6'b000001, 26'h0000_123};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic [1:0]  ir_src_mem;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, ld_wb_next;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .ir_src_mem(ir_src_mem), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next),
        .y_wb_next(y_wb_next), .ld_wb_next(ld_wb_next), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_next(input logic [31:0] ir, input logic [31:0] pc,
                             input logic [31:0] y, input logic [31:0] st);
        ir_mem_next = ir; pc_mem_next = pc; y_mem_next = y; st_mem_next = st;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0; ir_src_mem = SRC_DATA;
        load_next(I_LD, 32'h4, 32'h100, 32'h0);
        step(); step();
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
        tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%0b exp=0", mem_stall); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_bus_err got=%0b exp=0", bus_err); end
        tests++; if (ir_wb_next !== NOP) begin fails++; $display("FAIL reset_ir got=%h exp=%h", ir_wb_next, NOP); end
        tests++; if (pc_wb_next !== 32'h0 || y_wb_next !== 32'h0) begin fails++;
            $display("FAIL reset_pc_y got=%h/%h exp=0/0", pc_wb_next, y_wb_next); end
        tests++; if (ld_wb_next !== 32'h0) begin fails++; $display("FAIL reset_ld got=%h exp=0", ld_wb_next); end
        load_next(NOP, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        load_next(I_ADD, 32'h40, 32'h10, 32'h77);
        step();
        tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++;
            $display("FAIL alu_req_stall got=%0b/%0b exp=0/0", dmem_req, mem_stall); end
        tests++; if (ir_wb_next !== I_ADD) begin fails++; $display("FAIL alu_ir got=%h exp=%h", ir_wb_next, I_ADD); end
        tests++; if (y_wb_next !== 32'h10 || pc_wb_next !== 32'h40) begin fails++;
            $display("FAIL alu_y_pc got=%h/%h exp=10/40", y_wb_next, pc_wb_next); end
    endtask

    task automatic test_load_zero_wait();
        load_next(I_LD, 32'h44, 32'h100, 32'h0);
        step();
        load_next(I_ADD, 32'h48, 32'h55, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin fails++;
            $display("FAIL ld_bus got req=%0b we=%0b addr=%h exp 1/0/100", dmem_req, dmem_we, dmem_addr); end
        tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL ld_stall got=%0b exp=0", mem_stall); end
        tests++; if (ld_wb_next !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_data got=%h exp=deadbeef", ld_wb_next); end
        tests++; if (ir_wb_next !== I_LD) begin fails++; $display("FAIL ld_ir got=%h exp=%h", ir_wb_next, I_LD); end
        step();
        dmem_ack = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || ir_wb_next !== I_ADD) begin fails++;
            $display("FAIL ld_after got req=%0b ir=%h exp 0/%h", dmem_req, ir_wb_next, I_ADD); end
    endtask

    task automatic test_store_wait();
        int stall_errs = 0;
        load_next(I_ST, 32'h50, 32'h200, 32'h1234);
        step();
        load_next(I_ADD, 32'h54, 32'h300, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
                dmem_wdata !== 32'h1234 || mem_stall !== 1'b1 || ir_wb_next !== NOP ||
                y_wb_next !== 32'h200) begin
                stall_errs++;
                $display("FAIL st_stall_cyc%0d got req=%0b we=%0b addr=%h wd=%h stall=%0b ir=%h y=%h", i,
                         dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, ir_wb_next, y_wb_next);
            end
            step();
        end
        tests++; if (stall_errs != 0) fails++;
        dmem_ack = 1'b1;
        #1;
        tests++; if (mem_stall !== 1'b0 || ir_wb_next !== I_ST || dmem_req !== 1'b1) begin fails++;
            $display("FAIL st_ack got stall=%0b ir=%h req=%0b exp 0/%h/1", mem_stall, ir_wb_next, dmem_req, I_ST); end
        step();
        dmem_ack = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || ir_wb_next !== I_ADD || y_wb_next !== 32'h300) begin fails++;
            $display("FAIL st_after got req=%0b ir=%h y=%h exp 0/%h/300", dmem_req, ir_wb_next, y_wb_next, I_ADD); end
    endtask

    task automatic test_killed_store();
        load_next(I_ST, 32'h60, 32'h400, 32'h99);
        step();
        load_next(I_ADD, 32'h64, 32'h11, 32'h0);
        ir_src_mem = SRC_NOP;
        #1;
        tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || ir_wb_next !== NOP) begin fails++;
            $display("FAIL kill_st got req=%0b stall=%0b ir=%h exp 0/0/%h", dmem_req, mem_stall, ir_wb_next, NOP); end
        step();
        ir_src_mem = SRC_EXCEPT;
        #1;
        tests++; if (ir_wb_next !== BNE_EXC || y_wb_next !== 32'h11) begin fails++;
            $display("FAIL except_mux got ir=%h y=%h exp %h/11", ir_wb_next, y_wb_next, BNE_EXC); end
        ir_src_mem = SRC_DATA;
    endtask

    task automatic test_src_change_in_wait();
        load_next(I_LD, 32'h70, 32'h500, 32'h0);
        step();
        load_next(I_ADD, 32'h74, 32'h22, 32'h0);
        step();
        ir_src_mem = SRC_NOP;
        #1;
        tests++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || ir_wb_next !== NOP) begin fails++;
            $display("FAIL wait_kill got req=%0b stall=%0b ir=%h exp 1/1/%h", dmem_req, mem_stall, ir_wb_next, NOP); end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001; ir_src_mem = SRC_EXCEPT;
        #1;
        tests++; if (mem_stall !== 1'b0 || ir_wb_next !== BNE_EXC || ld_wb_next !== 32'hCAFE_0001) begin fails++;
            $display("FAIL wait_done got stall=%0b ir=%h ld=%h exp 0/%h/cafe0001", mem_stall, ir_wb_next, ld_wb_next, BNE_EXC); end
        step();
        dmem_ack = 1'b0; ir_src_mem = SRC_DATA;
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        int wait_errs = 0;
        load_next(I_LD, 32'h80, 32'h600, 32'h0);
        step();
        load_next(I_ADD, 32'h84, 32'h33, 32'h0);
        #1;
        tests++; if (mem_stall !== 1'b1 || bus_err !== 1'b0) begin fails++;
            $display("FAIL to_first got stall=%0b err=%0b exp 1/0", mem_stall, bus_err); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || bus_err !== 1'b0) begin
                wait_errs++;
                $display("FAIL to_wait_cyc%0d got stall=%0b req=%0b err=%0b exp 1/1/0", i, mem_stall, dmem_req, bus_err);
            end
        end
        tests++; if (wait_errs != 0) fails++;
        step();
        tests++; if (bus_err !== 1'b1 || ir_wb_next !== BNE_EXC || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin fails++;
            $display("FAIL to_abort got err=%0b ir=%h stall=%0b req=%0b exp 1/%h/0/0", bus_err, ir_wb_next, mem_stall, dmem_req, BNE_EXC); end
        step();
        tests++; if (bus_err !== 1'b0 || dmem_req !== 1'b0 || ir_wb_next !== I_ADD) begin fails++;
            $display("FAIL to_idle got err=%0b req=%0b ir=%h exp 0/0/%h", bus_err, dmem_req, ir_wb_next, I_ADD); end
    endtask
`else
    task automatic test_wait_forever();
        int wait_errs = 0;
        load_next(I_LD, 32'h80, 32'h600, 32'h0);
        step();
        load_next(I_ADD, 32'h84, 32'h33, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || bus_err !== 1'b0) begin
                wait_errs++;
                $display("FAIL noto_cyc%0d got stall=%0b req=%0b err=%0b exp 1/1/0", i, mem_stall, dmem_req, bus_err);
            end
            step();
        end
        tests++; if (wait_errs != 0) fails++;
        dmem_ack = 1'b1;
        #1;
        tests++; if (mem_stall !== 1'b0 || ir_wb_next !== I_LD) begin fails++;
            $display("FAIL noto_ack got stall=%0b ir=%h exp 0/%h", mem_stall, ir_wb_next, I_LD); end
        step();
        dmem_ack = 1'b0;
    endtask
`endif

    task automatic test_reset_in_wait();
        load_next(I_LD, 32'h90, 32'h700, 32'h0);
        step();
        load_next(I_ADD, 32'h94, 32'h44, 32'h0);
        step();
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rstw_pre got req=%0b exp 1", dmem_req); end
        rst_n = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0) begin fails++;
            $display("FAIL rstw_req got req=%0b stall=%0b err=%0b exp 0/0/0", dmem_req, mem_stall, bus_err); end
        step();
        rst_n = 1'b1;
        #1;
        tests++; if (ir_wb_next !== NOP || dmem_req !== 1'b0 || y_wb_next !== 32'h0) begin fails++;
            $display("FAIL rstw_after got ir=%h req=%0b y=%h exp %h/0/0", ir_wb_next, dmem_req, y_wb_next, NOP); end
        step();
        tests++; if (ir_wb_next !== I_ADD) begin fails++; $display("FAIL rstw_resume got ir=%h exp %h", ir_wb_next, I_ADD); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_store_wait();
        test_killed_store();
        test_src_change_in_wait();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
